// File: rtl/md5_pkg.sv
`default_nettype none
// ============================================================================
// Module   : md5_pkg
// Purpose  : Shared constants and types for the single-block MD5 core:
//            per-step additive constants K[0..63], per-step rotate amounts
//            s[0..63], the four chaining-value IVs, the FSM state type,
//            the step count and a 32-bit byte-swap helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package md5_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_FINAL = 2'd2
    } md5_state_t;

    localparam int C_STEP_COUNT = 64;

    localparam logic [31:0] C_IV_A = 32'h67452301;
    localparam logic [31:0] C_IV_B = 32'hefcdab89;
    localparam logic [31:0] C_IV_C = 32'h98badcfe;
    localparam logic [31:0] C_IV_D = 32'h10325476;

    localparam logic [31:0] C_K_TABLE [0:63] = '{
        32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
        32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
        32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
        32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
        32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
        32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
        32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
        32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
        32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
        32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
        32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
        32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
        32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
        32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
        32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
        32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
    };

    localparam logic [4:0] C_S_TABLE [0:63] = '{
        5'd7, 5'd12, 5'd17, 5'd22, 5'd7, 5'd12, 5'd17, 5'd22,
        5'd7, 5'd12, 5'd17, 5'd22, 5'd7, 5'd12, 5'd17, 5'd22,
        5'd5, 5'd9,  5'd14, 5'd20, 5'd5, 5'd9,  5'd14, 5'd20,
        5'd5, 5'd9,  5'd14, 5'd20, 5'd5, 5'd9,  5'd14, 5'd20,
        5'd4, 5'd11, 5'd16, 5'd23, 5'd4, 5'd11, 5'd16, 5'd23,
        5'd4, 5'd11, 5'd16, 5'd23, 5'd4, 5'd11, 5'd16, 5'd23,
        5'd6, 5'd10, 5'd15, 5'd21, 5'd6, 5'd10, 5'd15, 5'd21,
        5'd6, 5'd10, 5'd15, 5'd21, 5'd6, 5'd10, 5'd15, 5'd21
    };

    // Digest words are emitted little-endian, so each word is byte-reversed
    // before being placed MSB-first on the output bus.
    function automatic logic [31:0] byte_swap32(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/md5_round.sv
`default_nettype none
// ============================================================================
// Module   : md5_round
// Purpose  : One combinational MD5 step: selects F/G/H/I and the message word
//            for the step index, adds K[i], rotates left by s[i] and rotates
//            the A..D registers.
// Ports    : i_step        step index 0..63
//            i_block       padded 512-bit block, word j at bits [32j +: 32]
//            i_a..i_d      current chaining registers
//            o_a..o_d      chaining registers after this step
// Revision : 1.0 - initial release
// ============================================================================
module md5_round
    import md5_pkg::*;
(
    input  logic [5:0]   i_step,
    input  logic [511:0] i_block,
    input  logic [31:0]  i_a,
    input  logic [31:0]  i_b,
    input  logic [31:0]  i_c,
    input  logic [31:0]  i_d,
    output logic [31:0]  o_a,
    output logic [31:0]  o_b,
    output logic [31:0]  o_c,
    output logic [31:0]  o_d
);

    logic [31:0] w_f;
    logic [3:0]  w_g;
    logic [31:0] w_m;
    logic [4:0]  w_s;
    logic [31:0] w_sum;
    logic [31:0] w_rot;

    always_comb begin
        w_f = '0;
        w_g = '0;
        // Message index arithmetic is mod 16, so the 4-bit truncation of
        // the products is exactly what the algorithm needs.
        case (i_step[5:4])
            2'd0: begin
                w_f = (i_b & i_c) | (~i_b & i_d);
                w_g = i_step[3:0];
            end
            2'd1: begin
                w_f = (i_d & i_b) | (~i_d & i_c);
                w_g = i_step[3:0] * 4'd5 + 4'd1;
            end
            2'd2: begin
                w_f = i_b ^ i_c ^ i_d;
                w_g = i_step[3:0] * 4'd3 + 4'd5;
            end
            default: begin
                w_f = i_c ^ (i_b | ~i_d);
                w_g = i_step[3:0] * 4'd7;
            end
        endcase
        w_m   = i_block[{w_g, 5'b00000} +: 32];
        w_s   = C_S_TABLE[i_step];
        w_sum = i_a + w_f + C_K_TABLE[i_step] + w_m;
        // s is never 0, so the right-shift amount stays within 1..31.
        w_rot = (w_sum << w_s) | (w_sum >> (6'd32 - {1'b0, w_s}));
    end

    assign o_a = i_d;
    assign o_b = i_b + w_rot;
    assign o_c = i_b;
    assign o_d = i_c;

endmodule
`default_nettype wire

// File: rtl/md5_hash_core.sv
`default_nettype none
// ============================================================================
// Module   : md5_hash_core
// Purpose  : Single-block MD5 of a 0..16 byte message. Accepts a request when
//            idle, runs 64 steps (one per clock), then publishes the digest.
// Ports    : clock          rising-edge clock
//            reset          asynchronous active-low reset
//            msg_in         message, byte i at [8i:8i+7]
//            msg_in_width   length in bytes (values > 16 clamp to 16)
//            msg_in_valid   request strobe
//            msg_output     digest, canonical hex byte 0 at [0:7]
//            msg_out_valid  one-cycle pulse when a new digest is presented
//            ready          idle, next request will be accepted
// Revision : 1.0 - initial release
// ============================================================================
module md5_hash_core
    import md5_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    input  logic [0:127] msg_in,
    input  logic [0:7]   msg_in_width,
    input  logic         msg_in_valid,
    output logic [0:127] msg_output,
    output logic         msg_out_valid,
    output logic         ready
);

    md5_state_t   r_state;
    logic [5:0]   r_count;
    logic [0:127] r_msg;
    logic [4:0]   r_width;
    logic [31:0]  r_a, r_b, r_c, r_d;

    logic [4:0]   w_width_clamped;
    logic [511:0] w_block;
    logic [31:0]  w_a_next, w_b_next, w_c_next, w_d_next;

    assign w_width_clamped = (msg_in_width > 8'd16) ? 5'd16 : 5'(msg_in_width);

    // Padded block: byte k lives at w_block[8k +: 8], which makes each
    // 32-bit word the little-endian assembly of its four bytes.
    always_comb begin
        w_block = '0;
        for (int k = 0; k < 16; k++) begin
            if (5'(k) < r_width) begin
                w_block[8*k +: 8] = r_msg[8*k +: 8];
            end else if (5'(k) == r_width) begin
                w_block[8*k +: 8] = 8'h80;
            end
        end
        if (r_width == 5'd16) begin
            w_block[128 +: 8] = 8'h80;
        end
        // Bit length fits in one byte (max 128); upper length bytes stay 0.
        w_block[448 +: 64] = {56'd0, r_width, 3'b000};
    end

    md5_round u_round (
        .i_step  (r_count),
        .i_block (w_block),
        .i_a     (r_a),
        .i_b     (r_b),
        .i_c     (r_c),
        .i_d     (r_d),
        .o_a     (w_a_next),
        .o_b     (w_b_next),
        .o_c     (w_c_next),
        .o_d     (w_d_next)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_count       <= '0;
            r_msg         <= '0;
            r_width       <= '0;
            r_a           <= '0;
            r_b           <= '0;
            r_c           <= '0;
            r_d           <= '0;
            msg_output    <= '0;
            msg_out_valid <= 1'b0;
            ready         <= 1'b1;
        end else begin
            msg_out_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (msg_in_valid) begin
                        r_msg   <= msg_in;
                        r_width <= w_width_clamped;
                        r_a     <= C_IV_A;
                        r_b     <= C_IV_B;
                        r_c     <= C_IV_C;
                        r_d     <= C_IV_D;
                        r_count <= '0;
                        ready   <= 1'b0;
                        r_state <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    r_a     <= w_a_next;
                    r_b     <= w_b_next;
                    r_c     <= w_c_next;
                    r_d     <= w_d_next;
                    r_count <= r_count + 6'd1;
                    if (r_count == 6'(C_STEP_COUNT - 1)) begin
                        r_state <= ST_FINAL;
                    end
                end
                ST_FINAL: begin
                    msg_output    <= {byte_swap32(C_IV_A + r_a),
                                      byte_swap32(C_IV_B + r_b),
                                      byte_swap32(C_IV_C + r_c),
                                      byte_swap32(C_IV_D + r_d)};
                    msg_out_valid <= 1'b1;
                    ready         <= 1'b1;
                    r_state       <= ST_IDLE;
                end
                default: begin
                    ready   <= 1'b1;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_md5_hash_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_md5_hash_core
// Purpose  : Self-checking bench for md5_hash_core. Stimulus pushes expected
//            digests and pulse cycles into a scoreboard queue; a monitor pops
//            and compares on every msg_out_valid pulse.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_md5_hash_core;

    logic         clock;
    logic         reset;
    logic [0:127] msg_in;
    logic [0:7]   msg_in_width;
    logic         msg_in_valid;
    logic [0:127] msg_output;
    logic         msg_out_valid;
    logic         ready;

    md5_hash_core dut (
        .clock         (clock),
        .reset         (reset),
        .msg_in        (msg_in),
        .msg_in_width  (msg_in_width),
        .msg_in_valid  (msg_in_valid),
        .msg_output    (msg_output),
        .msg_out_valid (msg_out_valid),
        .ready         (ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc++;

    // mode 0: exact digest, 1: record digest, 2: must equal recorded digest
    typedef struct {
        logic [0:127] digest;
        int           cycle;
        int           mode;
    } exp_t;

    exp_t         q[$];
    logic [0:127] captured;
    int           checks   = 0;
    int           failures = 0;

    task automatic check_val(input string name, input logic [127:0] act,
                             input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clock) begin
        if (reset === 1'b1 && msg_out_valid !== 1'b0) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pulse actual=%h expected=no pulse (cycle %0d)",
                         msg_output, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                check_val("pulse_cycle", 128'(cyc), 128'(e.cycle));
                if (e.mode == 0) begin
                    check_val("digest", msg_output, e.digest);
                end else if (e.mode == 1) begin
                    captured = msg_output;
                end else begin
                    check_val("clamp_digest", msg_output, captured);
                end
            end
        end
    end

    // Issues a request when ready; accept edge is the next rising edge, so the
    // pulse is expected to be observed 65 edges later.
    task automatic send(input logic [0:127] m, input logic [7:0] w, input int mode,
                        input logic [0:127] exp, input bit keep_valid,
                        output int accept_cycle);
        int waited;
        waited = 0;
        accept_cycle = -1;
        while (ready !== 1'b1 && waited < 200) begin
            @(negedge clock);
            waited++;
        end
        if (ready !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=ready %b expected=1", ready);
            return;
        end
        msg_in       = m;
        msg_in_width = w;
        msg_in_valid = 1'b1;
        accept_cycle = cyc + 1;
        if (mode >= 0) q.push_back('{exp, accept_cycle + 65, mode});
        @(posedge clock);
        #1;
        if (!keep_valid) msg_in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 300) begin
            @(negedge clock);
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=%0d pending expected=0", q.size());
            q.delete();
        end
        repeat (5) @(negedge clock);
    endtask

    task automatic check_idle_outputs(input string tag, input bit check_out);
        check_val({tag, "_ready"}, 128'(ready), 128'(1));
        check_val({tag, "_valid"}, 128'(msg_out_valid), 128'(0));
        if (check_out) check_val({tag, "_output"}, msg_output, 128'h0);
    endtask

    localparam logic [0:127] C_EMPTY    = 128'hd41d8cd98f00b204e9800998ecf8427e;
    localparam logic [0:127] C_ABC      = 128'h900150983cd24fb0d6963f7d28e17f72;
    localparam logic [0:127] C_PASSWORD = 128'h5f4dcc3b5aa765d61d8327deb882cf99;
    localparam logic [0:127] C_MSGDIG   = 128'hf96b697d7cb7938d525a2f31aaf161d0;

    initial begin
        int acc;
        reset        = 1'b0;
        msg_in       = '0;
        msg_in_width = '0;
        msg_in_valid = 1'b0;
        captured     = '0;

        // Reset held with clock running
        repeat (3) begin
            @(negedge clock);
            check_idle_outputs("reset", 1'b1);
        end
        reset = 1'b1;

        // Empty string, accepted on the first edge after release
        send('0, 8'd0, 0, C_EMPTY, 1'b0, acc);
        drain();

        // Back-to-back: "abc" then "password" with valid held high
        send({"abc", 104'h0}, 8'd3, 0, C_ABC, 1'b1, acc);
        msg_in       = {"password", 64'h0};
        msg_in_width = 8'd8;
        q.push_back('{C_PASSWORD, acc + 66 + 65, 0});
        repeat (66) @(posedge clock);
        #1;
        msg_in_valid = 1'b0;
        drain();

        // Requests during ROUND must be ignored
        send({"message digest", 16'h0}, 8'd14, 0, C_MSGDIG, 1'b0, acc);
        repeat (10) @(posedge clock);
        msg_in       = {"abc", 104'h0};
        msg_in_width = 8'd3;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            msg_in_valid = (i % 2 == 0);
        end
        @(negedge clock);
        msg_in_valid = 1'b0;
        drain();
        repeat (80) @(negedge clock);

        // Width clamp: 16 and 200 must give identical digests
        send("0123456789abcdef", 8'd16, 1, '0, 1'b0, acc);
        drain();
        send("0123456789abcdef", 8'd200, 2, '0, 1'b0, acc);
        drain();

        // Reset in the middle of a hash aborts it
        send({"a", 120'h0}, 8'd1, -1, '0, 1'b0, acc);
        repeat (30) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check_idle_outputs("midreset", 1'b1);
        reset = 1'b1;
        repeat (80) @(negedge clock);
        check_idle_outputs("after_abort", 1'b1);

        send({"abc", 104'h0}, 8'd3, 0, C_ABC, 1'b0, acc);
        drain();

        check_val("queue_empty", 128'(q.size()), 128'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
